biquad_coef_sequencer: RTL

//  Coefficient configurator and frame scheduler for a cascade of NUM_SECTIONS biquad sections.

---
 rtl/biquad_pkg.sv | 35 +++
 rtl/biquad_coef_regfile.sv | 104 ++++++++++
 rtl/biquad_coef_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/biquad_pkg.sv
// -----------------------------------------------------------------------------
// biquad_pkg
// Shared definitions for the biquad coefficient sequencer slice.
//   - COEFS_PER_SECTION and the per-section coefficient index map
//     (k, a1, a2, b0, b1, b2 at indices 0..5).
//   - FSM state type for the frame scheduler (ST_IDLE, ST_BUSY).
//   - coef_addr_valid(): address legality check shared by the write path
//     and the optional readback path.
// Optional feature macro used by the slice: BIQUAD_COEF_READBACK_EN.
// -----------------------------------------------------------------------------
package biquad_pkg;

    localparam int COEFS_PER_SECTION = 6;

    localparam int COEF_K  = 0;
    localparam int COEF_A1 = 1;
    localparam int COEF_A2 = 2;
    localparam int COEF_B0 = 3;
    localparam int COEF_B1 = 4;
    localparam int COEF_B2 = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // An address names a real coefficient only if the section exists and
    // the index is one of the six coefficient slots (idx 6/7 are holes).
    function automatic logic coef_addr_valid(input int section,
                                             input int idx,
                                             input int num_sections);
        return (section < num_sections) && (idx < COEFS_PER_SECTION);
    endfunction

endpackage

// File: rtl/biquad_coef_regfile.sv
// -----------------------------------------------------------------------------
// biquad_coef_regfile
// Shadow + active coefficient storage for NUM_SECTIONS biquad sections.
// The host writes only the shadow bank; a single copy strobe moves the whole
// shadow bank into the active bank on one edge, so the cascade never sees a
// half-updated set.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset (both banks clear to 0)
//   wr_en        qualified shadow write (caller has already checked address
//                legality and write permission)
//   wr_addr      {section, idx[2:0]}
//   wr_data      coefficient value
//   copy         1 = active bank <= shadow bank on this edge
//   coef_out     active bank, section s idx i at [(s*6+i)*COEF_BDEPTH +: COEF_BDEPTH]
//   rd_addr, rd_sel, rd_data
//                only with BIQUAD_COEF_READBACK_EN: registered readback,
//                rd_sel 0 = active, 1 = shadow, illegal address reads 0
// -----------------------------------------------------------------------------
module biquad_coef_regfile
    import biquad_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int COEF_BDEPTH  = 12,
    parameter int AW           = $clog2(NUM_SECTIONS) + 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [COEF_BDEPTH-1:0] wr_data,
    input  logic                   copy,
`ifdef BIQUAD_COEF_READBACK_EN
    input  logic [AW-1:0]          rd_addr,
    input  logic                   rd_sel,
    output logic [COEF_BDEPTH-1:0] rd_data,
`endif
    output logic [NUM_SECTIONS*COEFS_PER_SECTION*COEF_BDEPTH-1:0] coef_out
);

    localparam int NWORDS = NUM_SECTIONS * COEFS_PER_SECTION;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [COEF_BDEPTH-1:0] shadow [NWORDS];
    logic [COEF_BDEPTH-1:0] active [NWORDS];

    // Flat word number of {section, idx}: section*6 + idx.
    function automatic logic [IW-1:0] word_index(input logic [AW-1:0] addr);
        return IW'(int'(addr[AW-1:3]) * COEFS_PER_SECTION + int'(addr[2:0]));
    endfunction

    // Shadow bank: one host word per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_en) begin
            shadow[word_index(wr_addr)] <= wr_data;
        end
    end

    // Active bank: whole-bank copy so every section switches on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                active[i] <= '0;
            end
        end else if (copy) begin
            for (int i = 0; i < NWORDS; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Flatten the active bank onto the cascade bus.
    always_comb begin
        coef_out = '0;
        for (int i = 0; i < NWORDS; i++) begin
            coef_out[i*COEF_BDEPTH +: COEF_BDEPTH] = active[i];
        end
    end

`ifdef BIQUAD_COEF_READBACK_EN
    logic rd_ok;

    assign rd_ok = coef_addr_valid(int'(rd_addr[AW-1:3]), int'(rd_addr[2:0]),
                                   NUM_SECTIONS);

    // Registered readback; holes in the address map read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (!rd_ok) begin
            rd_data <= '0;
        end else if (rd_sel) begin
            rd_data <= shadow[word_index(rd_addr)];
        end else begin
            rd_data <= active[word_index(rd_addr)];
        end
    end
`endif

endmodule

// File: rtl/biquad_coef_sequencer.sv
// -----------------------------------------------------------------------------
// biquad_coef_sequencer
// Coefficient configurator and frame scheduler for a cascade of NUM_SECTIONS
// biquad sections. Host writes land in a shadow bank; a commit copies the
// shadow bank to the active bank atomically, and only while no frame is in
// flight (ST_IDLE). Frames are tracked from the first section's valid_in
// (frame_valid rising edge) to the last section's valid_out (chain_done),
// with a timeout guarding against a lost chain_done.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data
//                 shadow write, accepted when wr_en & wr_ready;
//                 wr_addr = {section, idx[2:0]}, idx 0..5 = k,a1,a2,b0,b1,b2
//   wr_ready      0 while a commit is pending
//   wr_err        sticky: accepted write to idx 6/7 or missing section
//   commit_req    pulse: request shadow->active copy
//   commit_done   pulse on the cycle the active bank shows the new values
//   err_clr       clears wr_err and timeout_err (a same-cycle error wins)
//   frame_valid   level, rising edge = frame start
//   chain_done    pulse, frame finished
//   busy          1 in ST_BUSY
//   timeout_err   sticky: ST_BUSY lasted TIMEOUT_CYCLES without chain_done
//   coef_out      active bank, flattened
//   rd_addr, rd_sel, rd_data
//                 only with BIQUAD_COEF_READBACK_EN (see biquad_coef_regfile)
// -----------------------------------------------------------------------------
module biquad_coef_sequencer
    import biquad_pkg::*;
#(
    parameter int NUM_SECTIONS   = 4,
    parameter int COEF_BDEPTH    = 12,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int AW            = $clog2(NUM_SECTIONS) + 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [COEF_BDEPTH-1:0] wr_data,
    output logic                   wr_ready,
    output logic                   wr_err,
    input  logic                   commit_req,
    output logic                   commit_done,
    input  logic                   err_clr,
    input  logic                   frame_valid,
    input  logic                   chain_done,
    output logic                   busy,
    output logic                   timeout_err,
`ifdef BIQUAD_COEF_READBACK_EN
    input  logic [AW-1:0]          rd_addr,
    input  logic                   rd_sel,
    output logic [COEF_BDEPTH-1:0] rd_data,
`endif
    output logic [NUM_SECTIONS*COEFS_PER_SECTION*COEF_BDEPTH-1:0] coef_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic          pending;
    logic          frame_valid_d;
    logic [CW-1:0] timeout_cnt;

    logic          wr_accept;
    logic          wr_addr_ok;
    logic          shadow_we;
    logic          wr_bad;
    logic          frame_rise;
    logic          do_commit;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;
    logic          timeout_set;

    // Write qualification: a write offered while a commit is pending is
    // dropped silently; an accepted write to a hole only raises wr_err.
    always_comb begin
        wr_accept  = wr_en & wr_ready;
        wr_addr_ok = coef_addr_valid(int'(wr_addr[AW-1:3]), int'(wr_addr[2:0]),
                                     NUM_SECTIONS);
        shadow_we  = wr_accept & wr_addr_ok;
        wr_bad     = wr_accept & ~wr_addr_ok;
    end

    // Frame boundaries and commit window. A commit may share its edge with a
    // frame start: sections sample coefficients at least one cycle after
    // valid_in rises, so that frame already sees the new bank.
    always_comb begin
        frame_rise  = frame_valid & ~frame_valid_d;
        do_commit   = (state == ST_IDLE) & pending;
        cnt_inc     = (timeout_cnt == {CW{1'b1}}) ? timeout_cnt : timeout_cnt + CW'(1);
        timeout_hit = (cnt_inc == CW'(TIMEOUT_CYCLES));
        timeout_set = (state == ST_BUSY) & ~chain_done & timeout_hit;
    end

    // Frame scheduler, commit handshake and sticky error flags. chain_done
    // outside a frame is ignored; a pending commit waits for ST_IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            timeout_cnt   <= '0;
            frame_valid_d <= 1'b0;
            pending       <= 1'b0;
            wr_ready      <= 1'b1;
            commit_done   <= 1'b0;
            wr_err        <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            frame_valid_d <= frame_valid;
            commit_done   <= do_commit;

            case (state)
                ST_IDLE: begin
                    if (frame_rise) begin
                        state       <= ST_BUSY;
                        busy        <= 1'b1;
                        timeout_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (chain_done || timeout_hit) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timeout_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (do_commit) begin
                pending  <= 1'b0;
                wr_ready <= 1'b1;
            end else if (commit_req) begin
                pending  <= 1'b1;
                wr_ready <= 1'b0;
            end

            if (wr_bad) begin
                wr_err <= 1'b1;
            end else if (err_clr) begin
                wr_err <= 1'b0;
            end

            if (timeout_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    biquad_coef_regfile #(
        .NUM_SECTIONS (NUM_SECTIONS),
        .COEF_BDEPTH  (COEF_BDEPTH),
        .AW           (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (shadow_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .copy     (do_commit),
`ifdef BIQUAD_COEF_READBACK_EN
        .rd_addr  (rd_addr),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
`endif
        .coef_out (coef_out)
    );

endmodule
